// File: rtl/simple_memory_march_tester.sv
// rtl/simple_memory_march_tester.sv - March C- style tester for a small single-port memory
module simple_memory_march_tester #(
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] PATTERN    = 8'h55
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data
);

    typedef enum logic [3:0] {
        IDLE, W0,
        M1_RD, M1_CHK, M1_WR,
        M2_RD, M2_CHK, M2_WR,
        M3_RD, M3_CHK,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;
    localparam logic [DATA_WIDTH-1:0] PATTERN_N = ~PATTERN;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   addr, addr_nxt;
    logic                    pass_nxt;
    logic [ADDR_WIDTH-1:0]   fail_addr_nxt;
    logic [DATA_WIDTH-1:0]   fail_data_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
        end else begin
            state     <= state_nxt;
            addr      <= addr_nxt;
            pass      <= pass_nxt;
            fail_addr <= fail_addr_nxt;
            fail_data <= fail_data_nxt;
        end
    end

    assign mem_addr = addr;

    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr;
        pass_nxt      = pass;
        fail_addr_nxt = fail_addr;
        fail_data_nxt = fail_data;
        mem_write     = 1'b0;
        mem_wdata     = '0;
        busy          = 1'b1;
        done          = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    pass_nxt      = 1'b0;
                    fail_addr_nxt = '0;
                    fail_data_nxt = '0;
                    addr_nxt      = '0;
                    state_nxt     = W0;
                end
            end
            W0: begin
                mem_write = 1'b1;
                mem_wdata = PATTERN;
                if (addr == ADDR_MAX) begin
                    addr_nxt  = '0;
                    state_nxt = M1_RD;
                end else begin
                    addr_nxt = addr + 1'b1;
                end
            end
            M1_RD: state_nxt = M1_CHK;
            // A mismatch in any CHK state ends the run at once; pass is already 0 from start.
            M1_CHK: begin
                if (mem_rdata != PATTERN) begin
                    fail_addr_nxt = addr;
                    fail_data_nxt = mem_rdata;
                    pass_nxt      = 1'b0;
                    state_nxt     = DONE;
                end else begin
                    state_nxt = M1_WR;
                end
            end
            M1_WR: begin
                mem_write = 1'b1;
                mem_wdata = PATTERN_N;
                if (addr == ADDR_MAX) begin
                    addr_nxt  = ADDR_MAX;
                    state_nxt = M2_RD;
                end else begin
                    addr_nxt  = addr + 1'b1;
                    state_nxt = M1_RD;
                end
            end
            M2_RD: state_nxt = M2_CHK;
            M2_CHK: begin
                if (mem_rdata != PATTERN_N) begin
                    fail_addr_nxt = addr;
                    fail_data_nxt = mem_rdata;
                    pass_nxt      = 1'b0;
                    state_nxt     = DONE;
                end else begin
                    state_nxt = M2_WR;
                end
            end
            M2_WR: begin
                mem_write = 1'b1;
                mem_wdata = PATTERN;
                if (addr == '0) begin
                    addr_nxt  = '0;
                    state_nxt = M3_RD;
                end else begin
                    addr_nxt  = addr - 1'b1;
                    state_nxt = M2_RD;
                end
            end
            M3_RD: state_nxt = M3_CHK;
            M3_CHK: begin
                if (mem_rdata != PATTERN) begin
                    fail_addr_nxt = addr;
                    fail_data_nxt = mem_rdata;
                    pass_nxt      = 1'b0;
                    state_nxt     = DONE;
                end else if (addr == ADDR_MAX) begin
                    pass_nxt  = 1'b1;
                    state_nxt = DONE;
                end else begin
                    addr_nxt  = addr + 1'b1;
                    state_nxt = M3_RD;
                end
            end
            DONE: begin
                busy      = 1'b0;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_simple_memory_march_tester.sv
// tb/tb_simple_memory_march_tester.sv - scoreboard bench for simple_memory_march_tester
module tb_simple_memory_march_tester;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mem_write;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_addr;
    logic [7:0] fail_data;

    simple_memory_march_tester dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr),
        .fail_data (fail_data)
    );

    always #5 clk = ~clk;

    typedef struct { int c; int a; int d; } wr_t;
    typedef struct { int c; int p; int fa; int fd; } res_t;

    wr_t  wq[$];
    res_t rq[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int t0          = 0;
    int busy_total  = 0;

    // Single-port memory with an optional stuck-at cell seen on reads.
    logic [7:0] mem [16];
    bit         f_en  = 1'b0;
    int         f_addr = 0;
    int         f_bit  = 0;
    bit         f_val  = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_write) mem[mem_addr] <= mem_wdata;
    end

    function automatic logic [7:0] faulty(input logic [7:0] v, input int a);
        logic [7:0] r;
        r = v;
        if (f_en && a == f_addr) r[f_bit] = f_val;
        return r;
    endfunction

    always_comb mem_rdata = faulty(mem[mem_addr], int'(mem_addr));

    task automatic check_eq(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t  e;
        res_t r;
        if (busy === 1'b1) busy_total++;
        if (mem_write === 1'b1) begin
            e = wq.size() > 0 ? wq.pop_front() : '{-1, -1, -1};
            check_eq("wr_cycle", cyc - t0, e.c);
            check_eq("wr_addr", int'(mem_addr), e.a);
            check_eq("wr_data", int'(mem_wdata), e.d);
        end
        if (done === 1'b1) begin
            r = rq.size() > 0 ? rq.pop_front() : '{-1, -1, -1, -1};
            check_eq("done_cycle", cyc - t0, r.c);
            check_eq("done_pass", int'(pass), r.p);
            check_eq("done_fail_addr", int'(fail_addr), r.fa);
            check_eq("done_fail_data", int'(fail_data), r.fd);
            check_eq("done_busy", int'(busy), 0);
        end
    end

    task automatic push_w(input int c, input int a, input int d, input int abort_at);
        if (abort_at == 0 || c < abort_at) wq.push_back('{c, a, d});
    endtask

    // Algorithmic march over a model memory (with the same fault) to predict the write trace.
    task automatic plan_writes(input int abort_at);
        logic [7:0] m [16];
        int c;
        bit bad;
        c = 1;
        bad = 1'b0;
        for (int a = 0; a < 16; a++) begin
            push_w(c, a, 8'h55, abort_at); m[a] = 8'h55; c++;
        end
        for (int a = 0; a < 16 && !bad; a++) begin
            c++;
            if (faulty(m[a], a) != 8'h55) bad = 1'b1;
            else begin
                c++; push_w(c, a, 8'hAA, abort_at); m[a] = 8'hAA; c++;
            end
        end
        for (int a = 15; a >= 0 && !bad; a--) begin
            c++;
            if (faulty(m[a], a) != 8'hAA) bad = 1'b1;
            else begin
                c++; push_w(c, a, 8'h55, abort_at); m[a] = 8'h55; c++;
            end
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_write"}, int'(mem_write), 0);
        check_eq({tag, "_addr"}, int'(mem_addr), 0);
        check_eq({tag, "_wdata"}, int'(mem_wdata), 0);
        check_eq({tag, "_busy"}, int'(busy), 0);
        check_eq({tag, "_done"}, int'(done), 0);
        check_eq({tag, "_pass"}, int'(pass), 0);
        check_eq({tag, "_fail_addr"}, int'(fail_addr), 0);
        check_eq({tag, "_fail_data"}, int'(fail_data), 0);
    endtask

    task automatic do_run(input int lim, input int abort_at, input bit poke);
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        for (int n = 1; n <= lim; n++) begin
            @(negedge clk);
            start = poke && ((n >= 10 && n <= 50) || n == 145);
            if (n == 1) begin
                check_eq("start_busy", int'(busy), 1);
                check_eq("start_pass_clr", int'(pass), 0);
                check_eq("start_fa_clr", int'(fail_addr), 0);
                check_eq("start_fd_clr", int'(fail_data), 0);
            end
            if (abort_at > 0 && n == abort_at - 1) rst = 1'b1;
            if (abort_at > 0 && n == abort_at) begin
                rst = 1'b0;
                check_idle_zero("after_rst");
            end
            if (poke && (n == 146 || n == 147)) check_eq("start_in_done_ignored", int'(busy), 0);
        end
        check_eq("done_missing", rq.size(), 0);
        check_eq("writes_left", wq.size(), 0);
    endtask

    initial begin
        int b0;
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;

        // Clean run: full trace, timing, busy length, final memory contents.
        plan_writes(0);
        check_eq("plan_write_count", wq.size(), 48);
        rq.push_back('{145, 1, 0, 0});
        b0 = busy_total;
        do_run(150, 0, 1'b0);
        check_eq("busy_cycles", busy_total - b0, 144);
        for (int a = 0; a < 16; a++) check_eq("final_mem_55", int'(mem[a]), 8'h55);

        // start held high through cycles 10..50 and pulsed in the DONE cycle.
        plan_writes(0);
        rq.push_back('{145, 1, 0, 0});
        do_run(150, 0, 1'b1);
        check_eq("pass_held", int'(pass), 1);

        // Addr 5 bit 0 stuck-at-1.
        f_en = 1'b1; f_addr = 5; f_bit = 0; f_val = 1'b1;
        plan_writes(0);
        rq.push_back('{97, 0, 5, 8'hAB});
        do_run(115, 0, 1'b0);
        check_eq("fail_addr_held", int'(fail_addr), 5);

        // Addr 0 bit 7 stuck-at-0.
        f_addr = 0; f_bit = 7; f_val = 1'b0;
        plan_writes(0);
        rq.push_back('{112, 0, 0, 8'h2A});
        do_run(125, 0, 1'b0);

        // Reset at cycle 40 aborts without done or further writes.
        f_en = 1'b0;
        plan_writes(40);
        do_run(62, 40, 1'b0);

        plan_writes(0);
        rq.push_back('{145, 1, 0, 0});
        do_run(150, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
